// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
//   Shared types and constants for the MIPS pipeline front end.
//   - INSTR_W / PC_W     : datapath widths
//   - NOP_WORD           : encoding placed in IF/ID when it holds no instruction
//   - DEFAULT_HALT_WORD  : default encoding that ends the program
//   - DEFAULT_RESET_PC   : default byte PC after reset
//   - fetch_state_e      : fetch FSM states (RUN, HALTED)
//   - fetch_entry_t      : one fetched instruction plus its PC+4
//   - word_align()       : clears the byte-offset bits of a PC
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  localparam logic [INSTR_W-1:0] NOP_WORD          = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [PC_W-1:0]    DEFAULT_RESET_PC  = 32'h0000_0000;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc4;
  } fetch_entry_t;

  // Instructions are word aligned, so the two byte-offset bits are dropped.
  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] pc);
    return pc & ~PC_W'(3);
  endfunction

endpackage : cpu_pkg

// File: rtl/fetch_skid_queue.sv
// -----------------------------------------------------------------------------
// fetch_skid_queue
//   Two-entry FIFO of {instr, pc4} that catches instruction-memory responses
//   which arrive while the decode stage is stalled.
//   Ports:
//     CLOCK, RESET          clock, asynchronous active-high reset
//     enq                   push {enq_instr, enq_pc4}
//     deq                   pop the head entry
//     flush                 empty the queue (wins over enq and deq)
//     head_instr, head_pc4  head entry, meaningful only when count != 0
//     count                 number of valid entries (0..2)
//   A simultaneous enq + deq on a full queue is legal: the new entry takes the
//   slot the head vacates.
// -----------------------------------------------------------------------------
module fetch_skid_queue
  import cpu_pkg::*;
(
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic               enq,
  input  logic [INSTR_W-1:0] enq_instr,
  input  logic [PC_W-1:0]    enq_pc4,
  input  logic               deq,
  input  logic               flush,
  output logic [INSTR_W-1:0] head_instr,
  output logic [PC_W-1:0]    head_pc4,
  output logic [1:0]         count
);

  fetch_entry_t mem_q [2];
  logic         rd_ptr_q;
  logic         wr_ptr_q;
  logic [1:0]   count_q;

  logic         do_enq;
  logic         do_deq;
  logic [1:0]   count_d;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    do_deq  = 1'b0;
    do_enq  = 1'b0;
    count_d = count_q;
    if (!flush) begin
      do_deq = deq && (count_q != 2'd0);
      do_enq = enq && ((count_q != 2'd2) || do_deq);
      case ({do_enq, do_deq})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end else begin
      count_d = 2'd0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the clock edge.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_enq) wr_ptr_q <= ~wr_ptr_q;
      if (do_deq) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  // NOTE: the storage array is not reset; count_q alone says which slots hold
  // data, so clearing the payload would only add reset fan-out.
  always_ff @(posedge CLOCK) begin
    if (do_enq) mem_q[wr_ptr_q] <= '{instr: enq_instr, pc4: enq_pc4};
  end

  assign head_instr = mem_q[rd_ptr_q].instr;
  assign head_pc4   = mem_q[rd_ptr_q].pc4;
  assign count      = count_q;

endmodule : fetch_skid_queue

// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
//   Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the PC, drives a
//   synchronous word-addressed instruction RAM (1-cycle read latency) and
//   produces the IF/ID register. A 2-entry skid queue absorbs responses that
//   land while decode is stalled. Handles EX redirects and halt-word detection.
//
//   Parameters:
//     RESET_PC        byte PC loaded on reset
//     HALT_WORD       instruction encoding that ends the program
//   Ports:
//     CLOCK, RESET    clock, asynchronous active-high reset
//     stall           hold IF/ID, no dequeue
//     redirect_valid  taken branch/jump from EX (wins over stall)
//     redirect_pc     target byte PC (bits [1:0] ignored)
//     imem_en         read request this cycle
//     imem_addr       word address (pc >> 2)
//     imem_data       read data, valid the cycle after imem_en
//     if_id_instr     IF/ID instruction (NOP when invalid)
//     if_id_pc4       IF/ID PC+4
//     if_id_valid     IF/ID holds a real instruction
//     halted          halt word fetched, fetch stopped
//
//   Optional build macro IF_PERF_CNT_EN adds two saturating counters:
//     perf_fetch_cnt  instructions loaded into IF/ID
//     perf_stall_cnt  cycles with stall while IF/ID is valid
// -----------------------------------------------------------------------------
module if_fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0]    RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [INSTR_W-1:0] HALT_WORD = DEFAULT_HALT_WORD
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               imem_en,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc4,
  output logic               if_id_valid,
  output logic               halted
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_stall_cnt
`endif
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  fetch_state_e       state_q;
  logic [PC_W-1:0]    pc_q;
  logic [PC_W-1:0]    req_pc_q;      // byte PC of the read now in flight
  logic               inflight_q;    // a response is on imem_data this cycle
  logic [INSTR_W-1:0] if_id_instr_q;
  logic [PC_W-1:0]    if_id_pc4_q;
  logic               if_id_valid_q;

  // ---------------------------------------------------------------------------
  // Skid queue
  // ---------------------------------------------------------------------------
  logic [INSTR_W-1:0] q_head_instr;
  logic [PC_W-1:0]    q_head_pc4;
  logic [1:0]         q_count;

  // ---------------------------------------------------------------------------
  // Next-state decode
  // ---------------------------------------------------------------------------
  logic               resp_acc;
  logic               resp_is_halt;
  logic [PC_W-1:0]    resp_pc4;
  logic               bypass;
  logic               q_enq;
  logic               q_deq;
  logic               if_id_load;
  logic [INSTR_W-1:0] load_instr;
  logic [PC_W-1:0]    load_pc4;
  logic [2:0]         occupancy;
  logic               issue;

  always_comb begin
    // A response is dropped when a redirect kills it or fetch has halted.
    resp_acc     = inflight_q && (state_q == RUN) && !redirect_valid;
    resp_is_halt = resp_acc && (imem_data == HALT_WORD);
    resp_pc4     = req_pc_q + PC_W'(4);

    // Older queued entries must leave first, so a fresh response may only skip
    // the queue when it is empty and IF/ID is taking a new instruction.
    bypass       = resp_acc && (q_count == 2'd0) && !stall;
    q_enq        = resp_acc && !bypass;
    q_deq        = !redirect_valid && !stall && (q_count != 2'd0);
    if_id_load   = q_deq || bypass;
    load_instr   = q_deq ? q_head_instr : imem_data;
    load_pc4     = q_deq ? q_head_pc4   : resp_pc4;

    // Entries that will still need a slot after this cycle; a new read is only
    // launched if its response is guaranteed a place in the queue.
    occupancy    = {1'b0, q_count} + {2'b00, inflight_q} - {2'b00, if_id_load};
    issue        = !RESET && (state_q == RUN) && !redirect_valid &&
                   (occupancy < 3'd2);
  end

  // ---------------------------------------------------------------------------
  // PC, in-flight tracking, fetch FSM and IF/ID register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q       <= RUN;
      pc_q          <= word_align(RESET_PC);
      req_pc_q      <= '0;
      inflight_q    <= 1'b0;
      if_id_instr_q <= NOP_WORD;
      if_id_pc4_q   <= '0;
      if_id_valid_q <= 1'b0;
    end else if (redirect_valid) begin
      // Redirect wins over stall and halt; the response currently on
      // imem_data belongs to the wrong path and is simply not accepted.
      state_q       <= RUN;
      pc_q          <= word_align(redirect_pc);
      inflight_q    <= 1'b0;
      if_id_instr_q <= NOP_WORD;
      if_id_valid_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        pc_q     <= pc_q + PC_W'(4);
        req_pc_q <= pc_q;
      end
      if (resp_is_halt) state_q <= HALTED;
      if (!stall) begin
        if (if_id_load) begin
          if_id_instr_q <= load_instr;
          if_id_pc4_q   <= load_pc4;
          if_id_valid_q <= 1'b1;
        end else begin
          if_id_instr_q <= NOP_WORD;
          if_id_valid_q <= 1'b0;
        end
      end
    end
  end

  fetch_skid_queue u_skid_queue (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .enq        (q_enq),
    .enq_instr  (imem_data),
    .enq_pc4    (resp_pc4),
    .deq        (q_deq),
    .flush      (redirect_valid),
    .head_instr (q_head_instr),
    .head_pc4   (q_head_pc4),
    .count      (q_count)
  );

  // ---------------------------------------------------------------------------
  // Optional performance counters
  // ---------------------------------------------------------------------------
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_q;
  logic [31:0] perf_stall_q;
  logic        fetch_event;

  assign fetch_event = !redirect_valid && if_id_load;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (fetch_event && (perf_fetch_q != '1))
        perf_fetch_q <= perf_fetch_q + 32'd1;
      if (stall && if_id_valid_q && (perf_stall_q != '1))
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign imem_en     = issue;
  assign imem_addr   = pc_q >> 2;
  assign if_id_instr = if_id_instr_q;
  assign if_id_pc4   = if_id_pc4_q;
  assign if_id_valid = if_id_valid_q;
  assign halted      = (state_q == HALTED);

endmodule : if_fetch_stage

// File: tb/tb_if_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_stage
//   Directed bench for if_fetch_stage. A behavioural synchronous RAM returns
//   word_addr * 0x11, optionally with the halt word at byte address 0x0C.
//   Inputs change and outputs are sampled just after the falling clock edge.
//   "Cycle N" below means the N-th clock period after RESET is released.
// -----------------------------------------------------------------------------
module tb_if_fetch_stage;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_data = 32'h0;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        halted;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  logic        halt_en;
  int          n_tests = 0;
  int          n_fail  = 0;

  if_fetch_stage dut (
    .CLOCK          (CLOCK),
    .RESET          (RESET),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .if_id_instr    (if_id_instr),
    .if_id_pc4      (if_id_pc4),
    .if_id_valid    (if_id_valid),
    .halted         (halted)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 CLOCK = ~CLOCK;

  function automatic logic [31:0] ram_word(input logic [31:0] addr);
    if (halt_en && (addr == 32'd3)) return 32'hFFFF_FFFF;
    return addr * 32'h11;
  endfunction

  // Synchronous instruction RAM, one cycle read latency.
  always @(posedge CLOCK) begin
    if (imem_en) imem_data <= ram_word(imem_addr);
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    @(negedge CLOCK);
    #1;
  endtask

  task automatic check_if_id(input string tag, input logic [31:0] pc4);
    check({tag, "_valid"}, {31'b0, if_id_valid}, 32'd1);
    check({tag, "_pc4"},   if_id_pc4, pc4);
    check({tag, "_instr"}, if_id_instr, ((pc4 >> 2) - 32'd1) * 32'h11);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_en"},     {31'b0, imem_en},     32'd0);
    check({tag, "_addr"},   imem_addr,            32'd0);
    check({tag, "_valid"},  {31'b0, if_id_valid}, 32'd0);
    check({tag, "_instr"},  if_id_instr,          32'd0);
    check({tag, "_pc4"},    if_id_pc4,            32'd0);
    check({tag, "_halted"}, {31'b0, halted},      32'd0);
  endtask

  // Release RESET just after a falling edge; returns inside cycle 0.
  task automatic release_reset();
    @(negedge CLOCK);
    RESET = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    RESET          = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    halt_en        = 1'b0;

    // ---- 1: reset values, then streaming fetch ------------------------------
    repeat (2) @(negedge CLOCK);
    #1;
    check_reset_outputs("rst");
    release_reset();                                   // cycle 0
    check("c0_en",    {31'b0, imem_en},     32'd1);
    check("c0_addr",  imem_addr,            32'd0);
    check("c0_valid", {31'b0, if_id_valid}, 32'd0);
    tick();                                            // cycle 1
    check("c1_valid", {31'b0, if_id_valid}, 32'd0);
    check("c1_addr",  imem_addr,            32'd1);
    for (int c = 2; c <= 5; c++) begin
      tick();                                          // first valid at cycle 2
      check_if_id($sformatf("stream_c%0d", c), 32'(4 * (c - 1)));
    end

    // ---- 2: stall for three cycles mid-stream -------------------------------
    stall = 1'b1;                                      // cycle 5
    #1;
    check("st_c5_en",   {31'b0, imem_en}, 32'd1);
    check("st_c5_addr", imem_addr,        32'd5);
    for (int c = 6; c <= 7; c++) begin
      tick();                                          // queue fills, no issue
      check($sformatf("st_c%0d_en", c), {31'b0, imem_en}, 32'd0);
      check_if_id($sformatf("st_c%0d_hold", c), 32'd16);
    end
    tick();                                            // cycle 8
    stall = 1'b0;
    #1;
    check_if_id("st_c8_hold", 32'd16);
    check("st_c8_en",   {31'b0, imem_en}, 32'd1);
    check("st_c8_addr", imem_addr,        32'd6);
    for (int c = 9; c <= 12; c++) begin
      tick();                                          // no gap, dup or loss
      check_if_id($sformatf("rel_c%0d", c), 32'(4 * (c - 4)));
    end
`ifdef IF_PERF_CNT_EN
    check("perf_fetch", perf_fetch_cnt, 32'd8);
    check("perf_stall", perf_stall_cnt, 32'd3);
`endif

    // ---- 3: redirect while stalled with a full queue ------------------------
    stall = 1'b1;                                      // cycle 12
    #1;
    check("rd_c12_en", {31'b0, imem_en}, 32'd0);
    tick();                                            // cycle 13, queue full
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    #1;
    check("rd_c13_en", {31'b0, imem_en}, 32'd0);
    check_if_id("rd_c13_hold", 32'd32);
    tick();                                            // cycle 14
    redirect_valid = 1'b0;
    stall          = 1'b0;
    #1;
    check("rd_c14_valid", {31'b0, if_id_valid}, 32'd0);
    check("rd_c14_en",    {31'b0, imem_en},     32'd1);
    check("rd_c14_addr",  imem_addr,            32'h10);
    tick();                                            // cycle 15, stale dropped
    check("rd_c15_valid", {31'b0, if_id_valid}, 32'd0);
    tick();                                            // cycle 16
    check_if_id("rd_c16", 32'h44);
    tick();
    check_if_id("rd_c17", 32'h48);

    // ---- 4: halt word at byte 0x0C -------------------------------------------
    RESET   = 1'b1;
    halt_en = 1'b1;
    release_reset();                                   // cycle 0
    tick();
    tick();                                            // cycle 2
    check_if_id("h_c2", 32'd4);
    tick();
    check_if_id("h_c3", 32'd8);
    tick();                                            // cycle 4, halt on bus
    check_if_id("h_c4", 32'd12);
    check("h_c4_halted", {31'b0, halted}, 32'd0);
    tick();                                            // cycle 5
    check("h_c5_valid",  {31'b0, if_id_valid}, 32'd1);
    check("h_c5_instr",  if_id_instr,          32'hFFFF_FFFF);
    check("h_c5_pc4",    if_id_pc4,            32'h10);
    check("h_c5_halted", {31'b0, halted},      32'd1);
    check("h_c5_en",     {31'b0, imem_en},     32'd0);
    for (int c = 6; c <= 8; c++) begin
      tick();
      check($sformatf("h_c%0d_valid", c),  {31'b0, if_id_valid}, 32'd0);
      check($sformatf("h_c%0d_en", c),     {31'b0, imem_en},     32'd0);
      check($sformatf("h_c%0d_halted", c), {31'b0, halted},      32'd1);
    end

    // ---- 5: redirect out of HALTED (low PC bits ignored) ---------------------
    redirect_valid = 1'b1;                             // cycle 8
    redirect_pc    = 32'h103;
    #1;
    check("hr_c8_en", {31'b0, imem_en}, 32'd0);
    tick();                                            // cycle 9
    redirect_valid = 1'b0;
    #1;
    check("hr_c9_halted", {31'b0, halted}, 32'd0);
    check("hr_c9_en",     {31'b0, imem_en}, 32'd1);
    check("hr_c9_addr",   imem_addr,        32'h40);
    tick();
    check("hr_c10_valid", {31'b0, if_id_valid}, 32'd0);
    tick();                                            // cycle 11
    check_if_id("hr_c11", 32'h104);
    tick();
    check_if_id("hr_c12", 32'h108);

    // ---- 6: asynchronous reset with one queued entry and one in flight -------
    stall = 1'b1;                                      // cycle 12
    tick();                                            // cycle 13
    RESET   = 1'b1;
    stall   = 1'b0;
    halt_en = 1'b0;
    #1;
    check_reset_outputs("ar");
    release_reset();                                   // cycle 0
    check("ar_c0_en",   {31'b0, imem_en}, 32'd1);
    check("ar_c0_addr", imem_addr,        32'd0);
    tick();
    check("ar_c1_valid", {31'b0, if_id_valid}, 32'd0);
    tick();
    check_if_id("ar_c2", 32'd4);
    tick();
    check_if_id("ar_c3", 32'd8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_if_fetch_stage
